// File: rtl/sc_n_adder_tree.sv
// Stochastic scaled adder: N bitstreams through a registered, LFSR-selected 2:1 mux tree.
// Define SC_TREE_COUNT_EN to add the per-stream ones counter (ones_count / count_valid).

module sc_n_adder_tree_level #(
  parameter int W = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sel,
  input  logic [W-1:0]   d,
  output logic [W/2-1:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else for (int j = 0; j < W/2; j++) q[j] <= sel ? d[2*j+1] : d[2*j];
  end
endmodule

module sc_n_adder_tree #(
  parameter int              N          = 8,
  parameter int              STREAM_LEN = 256,
  parameter int              LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] SEED     = 16'hACE1,
  localparam int             CW         = $clog2(STREAM_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  inputs,
  output logic          out_valid,
  output logic          sum,
  output logic          busy,
  output logic          stream_done
`ifdef SC_TREE_COUNT_EN
  ,
  output logic [CW-1:0] ones_count,
  output logic          count_valid
`endif
);
  localparam int L = $clog2(N);
  localparam int P = 1 << L;
  localparam logic [CW-1:0] LAST = CW'(STREAM_LEN - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // Maximal-length Fibonacci feedback masks (bit i = tap i+1 of the polynomial).
  function automatic logic [LFSR_W-1:0] taps_for();
    case (LFSR_W)
      2:  return LFSR_W'(32'h0000_0003);
      3:  return LFSR_W'(32'h0000_0006);
      4:  return LFSR_W'(32'h0000_000C);
      5:  return LFSR_W'(32'h0000_0014);
      6:  return LFSR_W'(32'h0000_0030);
      7:  return LFSR_W'(32'h0000_0060);
      8:  return LFSR_W'(32'h0000_00B8);
      9:  return LFSR_W'(32'h0000_0110);
      10: return LFSR_W'(32'h0000_0240);
      11: return LFSR_W'(32'h0000_0500);
      12: return LFSR_W'(32'h0000_0829);
      13: return LFSR_W'(32'h0000_100D);
      14: return LFSR_W'(32'h0000_2015);
      15: return LFSR_W'(32'h0000_6000);
      16: return LFSR_W'(32'h0000_D008);
      17: return LFSR_W'(32'h0001_2000);
      18: return LFSR_W'(32'h0002_0400);
      19: return LFSR_W'(32'h0004_0023);
      20: return LFSR_W'(32'h0009_0000);
      21: return LFSR_W'(32'h0014_0000);
      22: return LFSR_W'(32'h0030_0000);
      23: return LFSR_W'(32'h0042_0000);
      24: return LFSR_W'(32'h00E1_0000);
      default: return LFSR_W'(32'h8020_0003);
    endcase
  endfunction
  localparam logic [LFSR_W-1:0] TAPS = taps_for();

  logic [1:0]        state;
  logic [CW-1:0]     in_cnt, out_cnt;
  logic [LFSR_W-1:0] lfsr;
  logic              accept, last_out;
  logic [L:0]        vld_pipe;
  logic [L:1]        vld_q;
  logic [2*P-2:0]    node;

  assign in_ready = (state == S_RUN);
  assign busy     = (state != S_IDLE);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= SEED;
    else      lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
  end

  always_comb vld_pipe = {vld_q, accept};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_q <= '0;
    else      vld_q <= vld_pipe[L-1:0];
  end
  assign out_valid = vld_pipe[L];

  // Data is gated by accept at the leaves, so bubbles flow as zeros and sum is 0 when not valid.
  // Heap-style packing: level k occupies node[2P - (2P>>k) +: P>>k]; the root is the top bit.
  assign node[P-1:0] = P'(inputs & {N{accept}});

  for (genvar l = 0; l < L; l++) begin : g_lvl
    localparam int WI = P >> l;
    localparam int OI = 2*P - ((2*P) >> l);
    localparam int OO = 2*P - ((2*P) >> (l+1));
    sc_n_adder_tree_level #(.W(WI)) u_lvl (
      .clk (clk),
      .rst (rst),
      .sel (lfsr[2*l+1]),
      .d   (node[OI +: WI]),
      .q   (node[OO +: WI/2])
    );
  end

  assign sum      = node[2*P-2];
  assign last_out = (state == S_DRAIN) && out_valid && (out_cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      in_cnt      <= '0;
      out_cnt     <= '0;
      stream_done <= 1'b0;
    end else begin
      stream_done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state   <= S_RUN;
          in_cnt  <= '0;
          out_cnt <= '0;
        end
        S_RUN: begin
          if (accept) begin
            in_cnt <= in_cnt + CW'(1);
            if (in_cnt == LAST) state <= S_DRAIN;
          end
          if (out_valid) out_cnt <= out_cnt + CW'(1);
        end
        S_DRAIN: if (out_valid) begin
          out_cnt <= out_cnt + CW'(1);
          if (last_out) begin
            state       <= S_IDLE;
            stream_done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SC_TREE_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ones_count  <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= last_out;
      if (state == S_IDLE && start) ones_count <= '0;
      else if (out_valid && sum)    ones_count <= ones_count + CW'(1);
    end
  end
`endif

endmodule
